// File: rtl/dmem_arbiter_if.sv
// Purpose: bundle of CPU MEM-stage, DMA and data-RAM signals around the dmem arbiter.
// Latency: none (wires only).
// Backpressure: carries cpu_stall / dma_gnt from the arbiter back to the requesters.
//
// Ports/modports:
//   slave  - arbiter view: takes CPU/DMA requests and mem_rdata, drives RAM controls,
//            cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_rvalid and owner.
//   master - environment view (pipeline, DMA engine, RAM): the mirror image.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  // CPU MEM-stage side
  logic              cpu_req_rd;
  logic              cpu_req_wr;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  // DMA / loader side
  logic              dma_req;
  logic              dma_we;
  logic [DATA_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  // Data RAM side
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  // Current port owner: 0 = CPU, 1 = DMA
  logic              owner;

  modport slave (
    input  cpu_req_rd, cpu_req_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata,
    output owner
  );

  modport master (
    output cpu_req_rd, cpu_req_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata,
    input  owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: single-port data-RAM arbiter, CPU priority with anti-starvation forced DMA bursts.
// Latency: CPU and DMA accesses issue in the request cycle; dma_rdata/dma_rvalid one cycle after grant.
// Backpressure: DMA holds dma_req until dma_gnt; CPU is frozen via cpu_stall while DMA owns the port.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   bus   - dmem_arbiter_if.slave: CPU request/response, DMA request/response,
//           data-RAM address/data/enables and the registered owner flag.
module dmem_arbiter #(
  parameter int DATA_W        = 32,
  parameter int STARVE_LIMIT  = 8,
  parameter int DMA_MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  // Counter widths; a limit of 1 still needs a 1-bit register.
  localparam int SW = (STARVE_LIMIT  > 1) ? $clog2(STARVE_LIMIT)  : 1;
  localparam int BW = (DMA_MAX_BURST > 1) ? $clog2(DMA_MAX_BURST) : 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BURST_LAST  = BW'(DMA_MAX_BURST - 1);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } state_t;

  state_t            state_q;
  logic [SW-1:0]     starve_cnt;
  logic [BW-1:0]     burst_cnt;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              dma_rvalid_q;

  logic              cpu_req;
  logic              cpu_wr;
  logic              cpu_rd;
  logic              contended;

  logic [DATA_W-1:0] port_addr;
  logic [DATA_W-1:0] port_wdata;
  logic              port_we;
  logic              port_re;
  logic              port_gnt;
  logic              port_stall;

  // A simultaneous load+store request is treated as a store.
  assign cpu_req   = bus.cpu_req_rd | bus.cpu_req_wr;
  assign cpu_wr    = bus.cpu_req_wr;
  assign cpu_rd    = bus.cpu_req_rd & ~bus.cpu_req_wr;
  assign contended = cpu_req & bus.dma_req;

  // Port mux. Control outputs depend only on requests and state, never on mem_rdata.
  always_comb begin
    port_addr  = bus.cpu_addr;
    port_wdata = bus.cpu_wdata;
    port_we    = 1'b0;
    port_re    = 1'b0;
    port_gnt   = 1'b0;
    port_stall = 1'b0;
    case (state_q)
      S_CPU: begin
        if (cpu_req) begin
          port_we = cpu_wr;
          port_re = cpu_rd;
        end else if (bus.dma_req) begin
          // CPU idle: let DMA use the free slot without changing ownership.
          port_addr  = bus.dma_addr;
          port_wdata = bus.dma_wdata;
          port_we    = bus.dma_we;
          port_re    = ~bus.dma_we;
          port_gnt   = 1'b1;
        end
      end
      S_DMA: begin
        port_addr  = bus.dma_addr;
        port_wdata = bus.dma_wdata;
        port_gnt   = bus.dma_req;
        port_we    = bus.dma_req & bus.dma_we;
        port_re    = bus.dma_req & ~bus.dma_we;
        port_stall = cpu_req;
      end
      default: ;
    endcase
    // No access may reach the RAM in a reset cycle.
    if (rst) begin
      port_we    = 1'b0;
      port_re    = 1'b0;
      port_gnt   = 1'b0;
      port_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CPU;
      starve_cnt   <= '0;
      burst_cnt    <= '0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      dma_rvalid_q <= port_gnt & ~bus.dma_we;
      if (port_gnt & ~bus.dma_we) begin
        dma_rdata_q <= bus.mem_rdata;
      end

      case (state_q)
        S_CPU: begin
          if (contended) begin
            if (starve_cnt == STARVE_LAST) begin
              // The CPU access in this cycle still completes; DMA takes over next cycle.
              state_q    <= S_DMA;
              starve_cnt <= '0;
              burst_cnt  <= '0;
            end else begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else begin
            // Either DMA is not waiting or it was just served opportunistically.
            starve_cnt <= '0;
          end
        end
        S_DMA: begin
          starve_cnt <= '0;
          // With dma_req high a grant always happens here, so the burst limit
          // check only needs the counter.
          if (!bus.dma_req || (burst_cnt == BURST_LAST)) begin
            state_q   <= S_CPU;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state_q <= S_CPU;
      endcase
    end
  end

  assign bus.mem_addr   = port_addr;
  assign bus.mem_wdata  = port_wdata;
  assign bus.mem_we     = port_we;
  assign bus.mem_re     = port_re;
  assign bus.dma_gnt    = port_gnt;
  assign bus.cpu_stall  = port_stall;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.owner      = (state_q == S_DMA);
  // Zero-latency load data, blanked whenever the CPU does not own the port.
  assign bus.cpu_rdata  = ((state_q == S_CPU) && !port_stall) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int SL = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DW)) bus ();

  dmem_arbiter #(
    .DATA_W       (DW),
    .STARVE_LIMIT (SL),
    .DMA_MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Combinational-read RAM, write committed at the clock edge.
  logic [31:0] ram [256];
  always @(posedge clk) if (bus.mem_we === 1'b1) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
  assign bus.mem_rdata = ram[bus.mem_addr[7:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks: is DMA in a forced burst, how long DMA has been refused,
  // how many burst grants were given, expected read-return and memory contents.
  bit          chk_en    = 0;
  bit          m_dma     = 0;
  int          m_refused = 0;
  int          m_grants  = 0;
  bit          m_rvalid  = 0;
  logic [31:0] m_rdata   = 32'h0;
  logic [31:0] shadow [256];

  logic        m_creq, m_cwr, m_crd, m_we, m_re, m_gnt, m_stall;
  logic [31:0] m_addr, m_wdata;
  int          m_who; // 0 = nobody, 1 = CPU, 2 = DMA

  always @(negedge clk) begin
    if (chk_en) begin
      m_cwr  = bus.cpu_req_wr;
      m_crd  = bus.cpu_req_rd && !m_cwr;
      m_creq = bus.cpu_req_rd || m_cwr;
      if (rst)        m_who = 0;
      else if (m_dma) m_who = bus.dma_req ? 2 : 0;
      else            m_who = m_creq ? 1 : (bus.dma_req ? 2 : 0);
      m_stall = !rst && m_dma && m_creq;
      m_gnt   = (m_who == 2);
      m_we    = (m_who == 1) ? m_cwr : (m_who == 2) ? bus.dma_we  : 1'b0;
      m_re    = (m_who == 1) ? m_crd : (m_who == 2) ? !bus.dma_we : 1'b0;
      m_addr  = (m_who == 2) ? bus.dma_addr  : bus.cpu_addr;
      m_wdata = (m_who == 2) ? bus.dma_wdata : bus.cpu_wdata;

      chk("owner",      bus.owner,      m_dma);
      chk("cpu_stall",  bus.cpu_stall,  m_stall);
      chk("dma_gnt",    bus.dma_gnt,    m_gnt);
      chk("mem_we",     bus.mem_we,     m_we);
      chk("mem_re",     bus.mem_re,     m_re);
      if (!rst && (m_who != 0 || !m_dma)) chk("mem_addr", bus.mem_addr, m_addr);
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("dma_rvalid", bus.dma_rvalid, m_rvalid);
      chk("dma_rdata",  bus.dma_rdata,  m_rdata);
      if (m_dma) chk("cpu_rdata_blocked", bus.cpu_rdata, 32'h0);
      else if (m_who == 1 && m_crd) chk("cpu_rdata", bus.cpu_rdata, shadow[bus.cpu_addr[7:0]]);

      if (rst) begin
        m_dma = 0; m_refused = 0; m_grants = 0; m_rvalid = 0; m_rdata = 32'h0;
      end else begin
        m_rvalid = m_gnt && !bus.dma_we;
        if (m_rvalid) m_rdata = shadow[bus.dma_addr[7:0]];
        if (m_we) shadow[m_addr[7:0]] = m_wdata;
        if (m_dma) begin
          if (m_gnt) m_grants++;
          if (!bus.dma_req || m_grants == MB) m_dma = 0;
        end else if (m_creq && bus.dma_req) begin
          m_refused++;
          if (m_refused == SL) begin
            m_dma = 1; m_refused = 0; m_grants = 0;
          end
        end else begin
          m_refused = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(); @(posedge clk); #1; endtask
  task automatic look(); #1; endtask
  task automatic idle();
    bus.cpu_req_rd = 0; bus.cpu_req_wr = 0; bus.dma_req = 0; bus.dma_we = 0;
  endtask
  task automatic cpu_load(input logic [31:0] a);
    bus.cpu_req_rd = 1; bus.cpu_req_wr = 0; bus.cpu_addr = a;
  endtask
  task automatic dma_set(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.dma_req = 1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  logic [23:0]  v_own, v_stl, v_gnt;
  logic [31:0]  rq[$];
  int           ngr, n;
  bit           g, seen;

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 32'h0; shadow[i] = 32'h0; end

    // 1. Reset with both sides requesting writes.
    rst = 1;
    bus.cpu_req_rd = 0; bus.cpu_req_wr = 1; bus.cpu_addr = 32'h08; bus.cpu_wdata = 32'h12345678;
    dma_set(1, 32'h30, 32'hDEADBEEF);
    #2;
    chk("rst0_mem_we", bus.mem_we, 0); chk("rst0_dma_gnt", bus.dma_gnt, 0); chk("rst0_stall", bus.cpu_stall, 0);
    step(); chk_en = 1; look();
    chk("rst1_mem_we", bus.mem_we, 0); chk("rst1_dma_gnt", bus.dma_gnt, 0); chk("rst1_stall", bus.cpu_stall, 0);
    chk("rst1_owner", bus.owner, 0);
    step(); rst = 0; look();
    chk("post_rst_owner", bus.owner, 0); chk("post_rst_cpu_we", bus.mem_we, 1);
    chk("post_rst_addr", bus.mem_addr, 32'h08); chk("post_rst_dma_gnt", bus.dma_gnt, 0);
    step(); idle();
    step(); cpu_load(32'h08); look();
    chk("cpu_wr_readback", bus.cpu_rdata, 32'h12345678);

    // 2. Opportunistic DMA write while the CPU is idle, then CPU load of it.
    step(); idle(); dma_set(1, 32'h10, 32'hA5A5A5A5); look();
    chk("opp_gnt", bus.dma_gnt, 1); chk("opp_we", bus.mem_we, 1); chk("opp_addr", bus.mem_addr, 32'h10);
    step(); idle(); cpu_load(32'h10); look();
    chk("opp_readback", bus.cpu_rdata, 32'hA5A5A5A5);
    step(); idle();

    // 3. Continuous contention: 8 CPU cycles, 4 DMA cycles, repeating.
    step(); cpu_load(32'h10); dma_set(0, 32'h08, 32'h0);
    for (int i = 0; i < 24; i++) begin
      look();
      v_own[i] = bus.owner; v_stl[i] = bus.cpu_stall; v_gnt[i] = bus.dma_gnt;
      step();
    end
    chk("contend_owner", {8'h0, v_own}, 32'h00F00F00);
    chk("contend_stall", {8'h0, v_stl}, 32'h00F00F00);
    chk("contend_gnt",   {8'h0, v_gnt}, 32'h00F00F00);
    idle();

    // 4. Preload 0x20..0x23 with 1..4, then a forced DMA read burst.
    for (int k = 0; k < 4; k++) begin
      step(); dma_set(1, 32'h20 + k, k + 1);
    end
    step(); idle();
    step(); cpu_load(32'h08); dma_set(0, 32'h20, 32'h0);
    ngr = 0;
    for (int i = 0; i < 16; i++) begin
      look();
      if (bus.dma_rvalid) rq.push_back(bus.dma_rdata);
      g = bus.dma_gnt;
      step();
      if (g) begin
        ngr++;
        bus.dma_addr = bus.dma_addr + 1;
        if (ngr == 4) bus.dma_req = 0;
      end
    end
    chk("burst_grants", ngr, 4);
    chk("burst_rvalid_count", rq.size(), 4);
    for (int i = 0; i < 4 && i < rq.size(); i++) chk("burst_rdata", rq[i], i + 1);
    idle();

    // 5. DMA drops its request after 2 of 4 burst grants.
    step(); cpu_load(32'h08); dma_set(0, 32'h20, 32'h0);
    ngr = 0;
    for (int i = 0; i < 30 && ngr < 2; i++) begin
      look();
      if (bus.dma_gnt) ngr++;
      step();
    end
    chk("drop_grants", ngr, 2);
    bus.dma_req = 0; look();
    chk("drop_owner_still", bus.owner, 1);
    step(); bus.dma_req = 1; look();
    chk("drop_owner_back", bus.owner, 0); chk("drop_stall_clear", bus.cpu_stall, 0);
    n = 0;
    while (bus.owner == 0 && n < 30) begin
      n++; step(); look();
    end
    chk("drop_starve_restart", n, 8);
    idle();
    step();

    // 6. Reset on the 2nd cycle of a forced DMA write burst.
    step(); dma_set(1, 32'h41, 32'h11111111);
    step(); idle();
    step(); cpu_load(32'h08); dma_set(1, 32'h40, 32'hD0D0D0D0);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      look();
      if (bus.dma_gnt) seen = 1;
      step();
    end
    chk("rstburst_first_grant", seen, 1);
    bus.dma_addr = 32'h41; bus.dma_wdata = 32'hBADBAD00; rst = 1; look();
    chk("rstburst_mem_we", bus.mem_we, 0); chk("rstburst_gnt", bus.dma_gnt, 0);
    chk("rstburst_stall", bus.cpu_stall, 0);
    step(); rst = 0; look();
    chk("rstburst_owner", bus.owner, 0);
    step(); idle();
    step(); cpu_load(32'h41); look();
    chk("rstburst_cpu_read", bus.cpu_rdata, 32'h11111111);
    chk("rstburst_ram41", ram[8'h41], 32'h11111111);
    chk("rstburst_ram40", ram[8'h40], 32'hD0D0D0D0);
    step(); idle();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
